// File: rtl/arith_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// arith_op_sequencer_if
// Handshake bus between the operation sequencer and the shared fixed/floating
// add/multiply datapath.
//
// Signals:
//   num1, num2   operand A / operand B              (sequencer -> unit)
//   op           {fixed, mult} operation select     (sequencer -> unit)
//   op_start     one-cycle start pulse              (sequencer -> unit)
//   op_done      result valid                       (unit -> sequencer)
//   op_result    16-bit result                      (unit -> sequencer)
//   op_overflow  overflow flag                      (unit -> sequencer)
//
// Modports: master = sequencer side, slave = arithmetic unit side.
// ---------------------------------------------------------------------------
interface arith_op_sequencer_if;
   logic [15:0] num1;
   logic [15:0] num2;
   logic [1:0]  op;
   logic        op_start;
   logic        op_done;
   logic [15:0] op_result;
   logic        op_overflow;

   modport master (
      output num1, num2, op, op_start,
      input  op_done, op_result, op_overflow
   );

   modport slave (
      input  num1, num2, op, op_start,
      output op_done, op_result, op_overflow
   );
endinterface

// File: rtl/arith_op_sequencer.sv
// ---------------------------------------------------------------------------
// arith_op_sequencer
// Collects two 16-bit operands from the switches on successive button presses,
// then an operation select, starts the selected arithmetic unit, waits for its
// done handshake (with timeout) and registers result/overflow for display.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   sw[15:0]         operand switches
//   FlA/FlM/FiA/FiM  debounced level buttons (float add/mul, fixed add/mul)
//   unit             arith_op_sequencer_if.master (operands, op, start, done)
//   result[15:0]     registered final result (0xFFFF on timeout)
//   overflow         registered overflow, also set on timeout
//   result_valid     high only in RESULT
//   timeout          high in RESULT when the operation timed out
//   state[2:0]       FSM state: IDLE=0 WAIT_B=1 WAIT_OP=2 EXEC=3 RESULT=4
//
// Optional feature macro: ACCUMULATE_EN
//   When defined, a fixed-point press (FiA/FiM) in a non-timed-out RESULT
//   chains: num1<=result, num2<=sw, and the FSM goes straight to WAIT_OP.
// ---------------------------------------------------------------------------
module arith_op_sequencer #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          sw,
   input  logic                 FlA,
   input  logic                 FlM,
   input  logic                 FiA,
   input  logic                 FiM,
   arith_op_sequencer_if.master unit,
   output logic [15:0]          result,
   output logic                 overflow,
   output logic                 result_valid,
   output logic                 timeout,
   output logic [2:0]           state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      RESULT  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q;
   logic [15:0]      num1_q, num2_q, result_q;
   logic [1:0]       op_q;
   logic             op_start_q, overflow_q, result_valid_q, timeout_q;
   logic             any_q;
   logic [CNT_W-1:0] cnt_q;

   logic             any_d;
   logic             press_d;
   logic [1:0]       op_d;

   // Rising edge of "any button": a held or multi-button press counts once.
   assign any_d   = FlA | FlM | FiA | FiM;
   assign press_d = any_d & ~any_q;

   // Priority FiM > FiA > FlM > FlA when several buttons are high together.
   assign op_d = FiM ? 2'b11 :
                 FiA ? 2'b10 :
                 FlM ? 2'b01 : 2'b00;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         num1_q         <= '0;
         num2_q         <= '0;
         op_q           <= 2'b00;
         op_start_q     <= 1'b0;
         result_q       <= '0;
         overflow_q     <= 1'b0;
         result_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
         any_q          <= 1'b0;
         cnt_q          <= '0;
      end else begin
         any_q      <= any_d;
         op_start_q <= 1'b0;  // start is a single-cycle pulse
         case (state_q)
            IDLE: begin
               if (press_d) begin
                  num1_q  <= sw;
                  state_q <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (press_d) begin
                  num2_q  <= sw;
                  state_q <= WAIT_OP;
               end
            end
            WAIT_OP: begin
               if (press_d) begin
                  op_q       <= op_d;
                  cnt_q      <= '0;
                  op_start_q <= 1'b1;
                  state_q    <= EXEC;
               end
            end
            EXEC: begin
               // op_done is checked first so it wins over a same-cycle timeout.
               if (unit.op_done) begin
                  result_q       <= unit.op_result;
                  overflow_q     <= unit.op_overflow;
                  timeout_q      <= 1'b0;
                  result_valid_q <= 1'b1;
                  state_q        <= RESULT;
               end else if (cnt_q == CNT_LAST) begin
                  result_q       <= 16'hFFFF;
                  overflow_q     <= 1'b1;
                  timeout_q      <= 1'b1;
                  result_valid_q <= 1'b1;
                  state_q        <= RESULT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RESULT: begin
               // result/overflow/timeout hold until the next RESULT entry.
               if (press_d) begin
                  result_valid_q <= 1'b0;
`ifdef ACCUMULATE_EN
                  if ((FiA | FiM) && !timeout_q) begin
                     num1_q  <= result_q;
                     num2_q  <= sw;
                     state_q <= WAIT_OP;
                  end else begin
                     state_q <= IDLE;
                  end
`else
                  state_q <= IDLE;
`endif
               end
            end
            default: begin
               result_valid_q <= 1'b0;
               state_q        <= IDLE;
            end
         endcase
      end
   end

   assign unit.num1     = num1_q;
   assign unit.num2     = num2_q;
   assign unit.op       = op_q;
   assign unit.op_start = op_start_q;
   assign result        = result_q;
   assign overflow      = overflow_q;
   assign result_valid  = result_valid_q;
   assign timeout       = timeout_q;
   assign state         = state_q;

endmodule
